// File: rtl/next_pc_seq_pkg.sv
// Shared CPU definitions: sequencer state encoding, PC width and reset vector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package next_pc_seq_pkg;

   localparam int              PC_WIDTH  = 8;
   localparam logic [PC_WIDTH-1:0] RESET_VEC = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_BRANCH = 2'd2,
      ST_HALT   = 2'd3
   } seq_state_t;

endpackage

// File: rtl/next_pc_seq.sv
// Next-PC sequencer: steps the fetch address, takes branches via an external 2:1 mux, halts/resumes.
// Latency: pc updates one edge after an accepted fetch; a branch costs exactly one bubble cycle.
// Backpressure: fetch_ready=0 holds pc while fetch_valid stays high in FETCH.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start, halt_req     begin/resume fetching, request halt
//   br_valid, br_target branch request and destination (only looked at in FETCH)
//   fetch_ready         consumer accepts the current pc
//   mux_y               next-PC value from the external mux (sel ? br_tgt_q : pc_inc)
//   pc, pc_inc          registered fetch address and its +1 (mux input A)
//   br_tgt_q, sel       captured branch target (mux input B) and mux select
//   fetch_valid, halted status decoded from the state register
module next_pc_seq
   import next_pc_seq_pkg::*;
#(
   parameter int              PC_W     = PC_WIDTH,
   parameter logic [PC_W-1:0] RESET_PC = RESET_VEC
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            halt_req,
   input  logic            br_valid,
   input  logic [PC_W-1:0] br_target,
   input  logic            fetch_ready,
   input  logic [PC_W-1:0] mux_y,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_inc,
   output logic [PC_W-1:0] br_tgt_q,
   output logic            sel,
   output logic            fetch_valid,
   output logic            halted
);

   seq_state_t      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] br_tgt_d;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         br_tgt_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         br_tgt_q <= br_tgt_d;
      end
   end

   // Next-state and next-PC selection
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      br_tgt_d = br_tgt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // halt beats branch beats advance; a branch never advances pc
            if (halt_req) begin
               state_d = ST_HALT;
            end else if (br_valid) begin
               state_d  = ST_BRANCH;
               br_tgt_d = br_target;
            end else if (fetch_ready) begin
               pc_d = mux_y;
            end
         end
         ST_BRANCH: begin
            // halt abandons the branch with pc untouched
            if (halt_req) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_FETCH;
               pc_d    = mux_y;
            end
         end
         ST_HALT: begin
            if (start && !halt_req) state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are pure decodes of the registered state
   always_comb begin
      sel         = (state_q == ST_BRANCH);
      fetch_valid = (state_q == ST_FETCH);
      halted      = (state_q == ST_HALT);
      pc          = pc_q;
      pc_inc      = pc_q + PC_W'(1);
   end

endmodule

// File: tb/tb_next_pc_seq.sv
module tb_next_pc_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       halt_req;
   logic       br_valid;
   logic [7:0] br_target;
   logic       fetch_ready;
   logic [7:0] mux_y;
   logic [7:0] pc;
   logic [7:0] pc_inc;
   logic [7:0] br_tgt_q;
   logic       sel;
   logic       fetch_valid;
   logic       halted;

   int total = 0;
   int bad   = 0;

   // External next-PC mux living in the parent datapath
   assign mux_y = sel ? br_tgt_q : pc_inc;

   next_pc_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .halt_req    (halt_req),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .fetch_ready (fetch_ready),
      .mux_y       (mux_y),
      .pc          (pc),
      .pc_inc      (pc_inc),
      .br_tgt_q    (br_tgt_q),
      .sel         (sel),
      .fetch_valid (fetch_valid),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle before sampling / driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; br_valid = 1'b0;
      br_target = 8'h00; fetch_ready = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_pc", pc, 8'h00);
      chk("rst_pc_inc", pc_inc, 8'h01);
      chk("rst_tgt", br_tgt_q, 8'h00);
      chk("rst_sel", sel, 1'b0);
      chk("rst_fv", fetch_valid, 1'b0);
      chk("rst_halted", halted, 1'b0);

      // Start, then sequential fetch 00..03
      rst_n = 1'b1; start = 1'b1; fetch_ready = 1'b1;
      step();
      start = 1'b0;
      chk("fetch0_pc", pc, 8'h00);
      chk("fetch0_fv", fetch_valid, 1'b1);
      chk("fetch0_sel", sel, 1'b0);
      step(); chk("seq_pc1", pc, 8'h01);
      step(); chk("seq_pc2", pc, 8'h02);
      step(); chk("seq_pc3", pc, 8'h03);
      step(); step();
      chk("seq_pc5", pc, 8'h05);

      // Branch at pc=05 to 40 with fetch_ready high: one bubble
      br_valid = 1'b1; br_target = 8'h40;
      step();
      br_valid = 1'b0;
      chk("br_tgt", br_tgt_q, 8'h40);
      chk("br_sel", sel, 1'b1);
      chk("br_fv", fetch_valid, 1'b0);
      chk("br_pc_hold", pc, 8'h05);
      step();
      chk("br_pc", pc, 8'h40);
      chk("br_fv_back", fetch_valid, 1'b1);
      chk("br_sel_back", sel, 1'b0);

      // Branch to 22, then stall for 4 cycles
      br_valid = 1'b1; br_target = 8'h22;
      step();
      br_valid = 1'b0;
      step();
      chk("stall_pc0", pc, 8'h22);
      fetch_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_pc", pc, 8'h22);
         chk("stall_fv", fetch_valid, 1'b1);
      end

      // Branch to FF, then wrap to 00
      br_valid = 1'b1; br_target = 8'hFF;
      step();
      br_valid = 1'b0;
      step();
      chk("wrap_pcff", pc, 8'hFF);
      chk("wrap_inc", pc_inc, 8'h00);
      fetch_ready = 1'b1;
      step();
      chk("wrap_pc00", pc, 8'h00);

      // Branch to 10, then halt_req + br_valid together
      br_valid = 1'b1; br_target = 8'h10;
      step();
      br_valid = 1'b0;
      step();
      chk("halt_pre_pc", pc, 8'h10);
      halt_req = 1'b1; br_valid = 1'b1; br_target = 8'h77;
      step();
      halt_req = 1'b0; br_valid = 1'b0;
      chk("halt_halted", halted, 1'b1);
      chk("halt_pc", pc, 8'h10);
      chk("halt_tgt", br_tgt_q, 8'h10);
      chk("halt_fv", fetch_valid, 1'b0);
      chk("halt_sel", sel, 1'b0);
      step();
      chk("halt_hold_pc", pc, 8'h10);
      chk("halt_hold", halted, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("resume_pc", pc, 8'h10);
      chk("resume_fv", fetch_valid, 1'b1);
      chk("resume_halted", halted, 1'b0);
      step();
      chk("resume_adv", pc, 8'h11);

      // Halt during BRANCH leaves pc unchanged
      br_valid = 1'b1; br_target = 8'h50;
      step();
      br_valid = 1'b0;
      chk("brh_sel", sel, 1'b1);
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      chk("brh_halted", halted, 1'b1);
      chk("brh_pc", pc, 8'h11);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("brh_resume_pc", pc, 8'h11);
      chk("brh_resume_fv", fetch_valid, 1'b1);

      // Reset in the middle of BRANCH
      br_valid = 1'b1; br_target = 8'h40;
      step();
      br_valid = 1'b0;
      chk("rb_tgt", br_tgt_q, 8'h40);
      chk("rb_sel", sel, 1'b1);
      rst_n = 1'b0;
      step();
      chk("rb_pc", pc, 8'h00);
      chk("rb_tgt_clr", br_tgt_q, 8'h00);
      chk("rb_sel_clr", sel, 1'b0);
      chk("rb_fv", fetch_valid, 1'b0);
      chk("rb_halted", halted, 1'b0);

      // br_valid ignored in IDLE
      rst_n = 1'b1; br_valid = 1'b1; br_target = 8'h33;
      step();
      br_valid = 1'b0;
      chk("idle_tgt", br_tgt_q, 8'h00);
      chk("idle_fv", fetch_valid, 1'b0);
      chk("idle_sel", sel, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/next_pc_seq.md
NEXT_PC_SEQ -- requirements
Module: next_pc_seq

Interface
REQ-001 Parameters: PC_W, default 8, program-counter width; RESET_PC, default 8'h00, PC value after reset.
REQ-002 Clock is one clock, and reset is synchronous and active-low; the ports are listed below.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 start  in  1  begin/resume fetching.
REQ-006 halt_req  in  1  request halt.
REQ-007 br_valid  in  1  branch request (sampled only in FETCH).
REQ-008 br_target  in  8  branch destination.
REQ-009 fetch_ready  in  1  consumer accepts current fetch address.
REQ-010 mux_y  in  8  next-PC value returned by the external 2:1 select mux.
REQ-011 pc  out  8  current fetch address (registered).
REQ-012 pc_inc  out  8  pc+1 modulo 256; drives mux data input A.
REQ-013 br_tgt_q  out  8  captured branch target; drives mux data input B.
REQ-014 sel  out  1  mux select: 0=A (sequential), 1=B (branch).
REQ-015 fetch_valid  out  1  pc is a valid fetch address this cycle.
REQ-016 halted  out  1  sequencer in HALT.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, BRANCH and HALT, and its state register SHALL update only on the rising edge of clk.
REQ-018 In IDLE, the block SHALL drive fetch_valid=0 and sel=0; start=1 SHALL move the state to FETCH on the next edge.
REQ-019 In FETCH, the block SHALL drive fetch_valid=1 and sel=0.
REQ-020 In FETCH, when fetch_valid and fetch_ready are both 1, pc SHALL load mux_y (that is, pc+1) on the next edge.
REQ-021 In FETCH, when fetch_ready=0, pc SHALL hold.
REQ-022 In FETCH, br_valid=1 SHALL capture br_target into br_tgt_q and move to BRANCH; the pc SHALL NOT advance that cycle even if fetch_ready=1.
REQ-023 In BRANCH, the block SHALL drive sel=1 and fetch_valid=0; pc SHALL load mux_y (that is, br_tgt_q) on the next edge, and the state SHALL return to FETCH, giving exactly one bubble cycle.
REQ-024 br_valid SHALL be ignored in IDLE, BRANCH and HALT.
REQ-025 halt_req=1 in FETCH or BRANCH SHALL move the state to HALT on the next edge and SHALL take priority over both branch and advance.
REQ-026 A BRANCH interrupted by halt_req SHALL leave pc unchanged.
REQ-027 In HALT, the block SHALL drive halted=1, fetch_valid=0 and sel=0, and pc SHALL hold; start=1 with halt_req=0 SHALL resume in FETCH at the held pc.
REQ-028 Priority in FETCH SHALL be halt_req, then br_valid, then advance.
REQ-029 pc_inc SHALL be combinational pc+1 truncated to 8 bits, so 8'hFF yields 8'h00.
REQ-030 sel SHALL be a pure decode of the state register with no dependence on inputs.
REQ-031 br_tgt_q SHALL change only on a branch capture.

Reset
REQ-032 With rst_n=0 at an edge, the block SHALL set state=IDLE, pc=RESET_PC, br_tgt_q=8'h00, sel=0, fetch_valid=0 and halted=0; pc_inc SHALL then equal RESET_PC+1.
REQ-033 Reset SHALL override all inputs in any state, including mid-BRANCH, and SHALL discard any pending target.

Structure
REQ-034 A shared CPU package SHALL hold the 2-bit state encoding (IDLE=0, FETCH=1, BRANCH=2, HALT=3), the PC width and the reset vector constant.
REQ-035 The block SHALL instantiate no sub-module; the next-PC 2:1 mux SHALL remain external in the parent datapath, wired to pc_inc, br_tgt_q, sel and mux_y.

Verification
REQ-036 The bench SHALL model the external mux (mux_y = sel ? br_tgt_q : pc_inc) in every scenario.
REQ-037 Reset, then start pulse, fetch_ready=1 for 3 cycles -> pc steps 00,01,02,03; fetch_valid=1 from the first FETCH cycle.
REQ-038 pc=8'hFF in FETCH with fetch_ready=1 -> next pc=8'h00.
REQ-039 pc=8'h05 in FETCH with br_valid=1, br_target=8'h40 and fetch_ready=1 -> br_tgt_q=8'h40, one cycle with sel=1 and fetch_valid=0, then pc=8'h40 in FETCH.
REQ-040 halt_req and br_valid asserted together in FETCH with pc=8'h10 -> HALT, halted=1, pc=8'h10, br_tgt_q unchanged; a later start resumes FETCH at pc=8'h10.
REQ-041 fetch_ready=0 for 4 cycles in FETCH with pc=8'h22 -> pc holds at 8'h22 and fetch_valid stays 1.
REQ-042 rst_n=0 during BRANCH (br_tgt_q=8'h40) -> next cycle state=IDLE, pc=8'h00, br_tgt_q=8'h00, sel=0.
